// File: rtl/ysyx_22040729_inst_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_22040729_inst_fetch
//
// Instruction fetch unit. Walks a PC stream, issues one 32-bit read at a
// time to memory, buffers each returned word together with its PC in a
// small FIFO and hands the FIFO head to the decoder. A redirect flushes the
// FIFO, discards any response still in flight and restarts fetch at the
// new (word-aligned) PC.
//
// Handshakes: every channel is valid/ready. A transfer happens on the
// rising edge where valid and ready are both high. Valid never depends on
// ready. A memory response is a one-cycle pulse on i_rsp_valid that always
// belongs to the single outstanding request.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_redirect_valid    flush and restart fetch at i_redirect_pc
//   i_redirect_pc       redirect target (bits [1:0] ignored)
//   o_req_valid         memory read request valid
//   i_req_ready         memory accepts the request
//   o_req_addr          read address (current pc register)
//   i_rsp_valid         read data valid (single-cycle pulse)
//   i_rsp_data          returned instruction word
//   o_inst_valid        FIFO head valid
//   i_inst_ready        decoder consumes the FIFO head
//   o_inst, o_inst_pc   FIFO head instruction and its PC
//   o_dbg_state         FSM state (0 IDLE, 1 WAIT_RSP, 2 DROP)
// ---------------------------------------------------------------------------
module ysyx_22040729_inst_fetch #(
   parameter int                    INST_WIDTH = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 'h8000_0000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_redirect_valid,
   input  logic [DATA_WIDTH-1:0] i_redirect_pc,
   output logic                  o_req_valid,
   input  logic                  i_req_ready,
   output logic [DATA_WIDTH-1:0] o_req_addr,
   input  logic                  i_rsp_valid,
   input  logic [INST_WIDTH-1:0] i_rsp_data,
   output logic                  o_inst_valid,
   input  logic                  i_inst_ready,
   output logic [INST_WIDTH-1:0] o_inst,
   output logic [DATA_WIDTH-1:0] o_inst_pc,
   output logic [1:0]            o_dbg_state
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_RSP = 2'd1,
      S_DROP     = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [DATA_WIDTH-1:0] r_req_pc;

   logic [INST_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic w_req_valid;
   logic w_accept;
   logic w_push;
   logic w_pop;

   // ------------------------------------------------------------------
   // FSM next state and request valid
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_req_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Only request when a FIFO slot is free, so the response can
            // always be pushed. A redirect suppresses the request so no
            // stale address is ever accepted.
            w_req_valid = (r_count < DEPTH_C) && !i_redirect_valid;
            if (w_req_valid && i_req_ready) begin
               w_next_state = S_WAIT_RSP;
            end
         end
         S_WAIT_RSP: begin
            if (i_redirect_valid) begin
               // Response still to come must be swallowed in DROP.
               w_next_state = i_rsp_valid ? S_IDLE : S_DROP;
            end else if (i_rsp_valid) begin
               w_next_state = S_IDLE;
            end
         end
         S_DROP: begin
            if (i_rsp_valid) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_accept = w_req_valid && i_req_ready;
   assign w_push   = (r_state == S_WAIT_RSP) && i_rsp_valid && !i_redirect_valid;
   assign w_pop    = o_inst_valid && i_inst_ready;

   // ------------------------------------------------------------------
   // FSM state, PC and outstanding-request PC
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         r_state <= w_next_state;
         if (i_redirect_valid) begin
            r_pc <= {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
         end else if (w_accept) begin
            r_pc     <= r_pc + DATA_WIDTH'(4);
            r_req_pc <= r_pc;
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO control. Flush takes priority over a same-cycle pop.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst || i_redirect_valid) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // FIFO storage needs no reset; entries are only visible via r_count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_inst[r_wr_ptr] <= i_rsp_data;
         r_fifo_pc[r_wr_ptr]   <= r_req_pc;
      end
   end

   assign o_req_valid  = w_req_valid;
   assign o_req_addr   = r_pc;
   assign o_inst_valid = (r_count != '0);
   assign o_inst       = r_fifo_inst[r_rd_ptr];
   assign o_inst_pc    = r_fifo_pc[r_rd_ptr];
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_ysyx_22040729_inst_fetch.sv
module tb_ysyx_22040729_inst_fetch;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   // Expected {pc, instruction} for every word that must reach the decoder.
   logic [95:0] exp_q[$];

   ysyx_22040729_inst_fetch dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_req_valid      (req_valid),
      .i_req_ready      (req_ready),
      .o_req_addr       (req_addr),
      .i_rsp_valid      (rsp_valid),
      .i_rsp_data       (rsp_data),
      .o_inst_valid     (inst_valid),
      .i_inst_ready     (inst_ready),
      .o_inst           (inst),
      .o_inst_pc        (inst_pc),
      .o_dbg_state      (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- check helper ----------------
   function automatic void check(input string name, input logic [95:0] act,
                                 input logic [95:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endfunction

   // ---------------- monitor / scoreboard ----------------
   // Inputs change #1 after posedge, so the negedge sees the handshake
   // that the next posedge will commit.
   always @(negedge clk) begin
      if (!rst) begin
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_inst", {inst_pc, inst}, 96'h0);
               if ({inst_pc, inst} == 96'h0) begin
                  failures++;
                  $display("FAIL unexpected_inst: got %h expected none", {inst_pc, inst});
               end
            end else begin
               check("inst_head", {inst_pc, inst}, exp_q.pop_front());
            end
         end
         // Whatever is left in the FIFO is flushed by the redirect.
         if (redirect_valid) exp_q.delete();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Wait (bounded) for a request, check its address, let it be accepted
   // (req_ready must be 1), answer after lat cycles.
   task automatic issue(input logic [63:0] addr, input logic [31:0] data,
                        input int lat);
      int n = 0;
      @(negedge clk);
      while (!req_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_valid", {95'h0, req_valid}, 96'h1);
      check("req_addr", {32'h0, req_addr}, {32'h0, addr});
      tick();
      repeat (lat - 1) tick();
      rsp_valid = 1'b1;
      rsp_data  = data;
      exp_q.push_back({addr, data});
      tick();
      rsp_valid = 1'b0;
      check("inst_valid_after_rsp", {95'h0, inst_valid}, 96'h1);
   endtask

   task automatic drain_check(input string name);
      repeat (4) tick();
      check(name, 96'(exp_q.size()), 96'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      req_ready      = 1'b1;
      rsp_valid      = 1'b0;
      rsp_data       = 32'h0;
      inst_ready     = 1'b1;

      // 1: plain sequential fetch
      do_reset();
      check("rst_inst_valid", {95'h0, inst_valid}, 96'h0);
      check("rst_req_addr", {32'h0, req_addr}, {32'h0, 64'h8000_0000});
      check("rst_state", {94'h0, dbg_state}, 96'h0);
      issue(64'h8000_0000, 32'h0000_0013, 1);
      issue(64'h8000_0004, 32'h0010_0093, 1);
      issue(64'h8000_0008, 32'h0020_0113, 2);
      issue(64'h8000_000c, 32'h0030_8193, 1);
      drain_check("t1_drained");

      // 2: backpressure fills the FIFO, then fetch resumes
      do_reset();
      inst_ready = 1'b0;
      issue(64'h8000_0000, 32'h1111_1111, 1);
      issue(64'h8000_0004, 32'h2222_2222, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_req_valid", {95'h0, req_valid}, 96'h0);
         check("full_inst_valid", {95'h0, inst_valid}, 96'h1);
      end
      tick();
      inst_ready = 1'b1;
      issue(64'h8000_0008, 32'h3333_3333, 1);
      drain_check("t2_drained");

      // 3: redirect while waiting, response arrives later and is dropped
      do_reset();
      @(negedge clk);
      check("t3_req_addr", {32'h0, req_addr}, {32'h0, 64'h8000_0000});
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_1000;
      tick();
      redirect_valid = 1'b0;
      check("t3_drop_state", {94'h0, dbg_state}, 96'h2);
      tick();
      rsp_valid = 1'b1;
      rsp_data  = 32'hdead_beef;
      tick();
      rsp_valid = 1'b0;
      check("t3_discard", {95'h0, inst_valid}, 96'h0);
      check("t3_idle_state", {94'h0, dbg_state}, 96'h0);
      issue(64'h8000_1000, 32'h4444_4444, 1);
      drain_check("t3_drained");

      // 4: redirect in the same cycle as the response
      do_reset();
      @(negedge clk);
      tick();
      rsp_valid      = 1'b1;
      rsp_data       = 32'hbad0_bad0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_2002;
      tick();
      rsp_valid      = 1'b0;
      redirect_valid = 1'b0;
      check("t4_discard", {95'h0, inst_valid}, 96'h0);
      issue(64'h8000_2000, 32'h5555_5555, 1);
      drain_check("t4_drained");

      // 5: memory stall, redirect in IDLE, PC wrap
      do_reset();
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_req_valid", {95'h0, req_valid}, 96'h1);
         check("stall_req_addr", {32'h0, req_addr}, {32'h0, 64'h8000_0000});
      end
      tick();
      req_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hffff_ffff_ffff_fffe;
      @(negedge clk);
      check("redirect_gates_req", {95'h0, req_valid}, 96'h0);
      tick();
      redirect_valid = 1'b0;
      issue(64'hffff_ffff_ffff_fffc, 32'h6666_6666, 1);
      issue(64'h0000_0000_0000_0000, 32'h7777_7777, 1);
      drain_check("t5_drained");

      // 6: reset with a buffered word and a request outstanding
      do_reset();
      inst_ready = 1'b0;
      issue(64'h8000_0000, 32'h8888_8888, 1);
      @(negedge clk);
      check("t6_second_req", {32'h0, req_addr}, {32'h0, 64'h8000_0004});
      tick();
      check("t6_wait_state", {94'h0, dbg_state}, 96'h1);
      req_ready = 1'b0;
      do_reset();
      check("t6_inst_valid", {95'h0, inst_valid}, 96'h0);
      check("t6_req_addr", {32'h0, req_addr}, {32'h0, 64'h8000_0000});
      check("t6_state", {94'h0, dbg_state}, 96'h0);
      rsp_valid = 1'b1;
      rsp_data  = 32'h9999_9999;
      tick();
      rsp_valid = 1'b0;
      check("t6_late_rsp", {95'h0, inst_valid}, 96'h0);
      req_ready  = 1'b1;
      inst_ready = 1'b1;
      issue(64'h8000_0000, 32'haaaa_aaaa, 1);
      drain_check("t6_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
